// File: rtl/score_pkg.sv
// Shared definitions for the score BCD scheduler: FSM encoding and digit/score limits.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    localparam int BCD_DIGIT_W     = 4;
    localparam int MAX_SCORE       = 99;
    localparam int DEFAULT_TIMEOUT = 31;

endpackage

// File: rtl/score_bcd_scheduler_rr_pick.sv
// Round-robin picker: first set bit of i_dirty at or after i_ptr, wrapping at NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = 1
) (
    input  logic [NUM_CH-1:0] i_dirty,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic              o_found,
    output logic [SEL_W-1:0]  o_sel
);

    logic [SEL_W:0] w_idx;

    always_comb begin
        o_found = 1'b0;
        o_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, i_ptr} + (SEL_W+1)'(i);
            if (w_idx >= (SEL_W+1)'(NUM_CH)) begin
                w_idx = w_idx - (SEL_W+1)'(NUM_CH);
            end
            if (!o_found && i_dirty[w_idx[SEL_W-1:0]]) begin
                o_found = 1'b1;
                o_sel   = w_idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Shares one serial binary-to-BCD converter among NUM_CH score channels, round-robin.
// Optional build macro SCORE_BCD_CLAMP_EN clamps the converter operand to 99.
module score_bcd_scheduler
    import score_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int BIN_W   = 7,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH*BIN_W-1:0]       bin_i,
    output logic                          conv_start_o,
    output logic [BIN_W-1:0]              conv_bin_o,
    input  logic                          conv_done_i,
    input  logic [BCD_DIGIT_W-1:0]        conv_tens_i,
    input  logic [BCD_DIGIT_W-1:0]        conv_ones_i,
    output logic [NUM_CH*BCD_DIGIT_W-1:0] tens_o,
    output logic [NUM_CH*BCD_DIGIT_W-1:0] ones_o,
    output logic [NUM_CH-1:0]             valid_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [SEL_W-1:0]         r_ptr;
    logic [SEL_W-1:0]         r_sel;
    logic [SEL_W-1:0]         w_sel_inc;
    logic [BIN_W-1:0]         r_op;
    logic [BIN_W-1:0]         r_raw;
    logic [CNT_W-1:0]         r_cnt;
    logic [BCD_DIGIT_W-1:0]   r_tens_cap;
    logic [BCD_DIGIT_W-1:0]   r_ones_cap;
    logic                     r_timeout;
    logic                     w_timeout_hit;

    logic [BIN_W-1:0]         w_bin      [NUM_CH];
    logic [BIN_W-1:0]         r_shadow   [NUM_CH];
    logic [BCD_DIGIT_W-1:0]   r_tens     [NUM_CH];
    logic [BCD_DIGIT_W-1:0]   r_ones     [NUM_CH];
    logic                     r_valid    [NUM_CH];
    logic [NUM_CH-1:0]        w_dirty;
    logic                     w_found;
    logic [SEL_W-1:0]         w_pick;
    logic [BIN_W-1:0]         w_op_pick;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .i_dirty (w_dirty),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_sel   (w_pick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_bin[gi]   = bin_i[gi*BIN_W +: BIN_W];
            // A channel is dirty until first converted, and whenever its input moves off the last converted value.
            assign w_dirty[gi] = !r_valid[gi] || (w_bin[gi] != r_shadow[gi]);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_shadow[gi] <= '0;
                    r_tens[gi]   <= '0;
                    r_ones[gi]   <= '0;
                    r_valid[gi]  <= 1'b0;
                end else if (r_state == ST_STORE && r_sel == SEL_W'(gi)) begin
                    r_shadow[gi] <= r_raw;
                    r_tens[gi]   <= r_tens_cap;
                    r_ones[gi]   <= r_ones_cap;
                    r_valid[gi]  <= 1'b1;
                end
            end

            assign tens_o[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = r_tens[gi];
            assign ones_o[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = r_ones[gi];
            assign valid_o[gi]                           = r_valid[gi];
        end
    endgenerate

`ifdef SCORE_BCD_CLAMP_EN
    assign w_op_pick = (w_bin[w_pick] > BIN_W'(MAX_SCORE)) ? BIN_W'(MAX_SCORE) : w_bin[w_pick];
`else
    assign w_op_pick = w_bin[w_pick];
`endif

    assign w_sel_inc     = (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
    // Done in the same cycle as the last allowed WAIT cycle takes priority over the abort.
    assign w_timeout_hit = (r_state == ST_WAIT) && !conv_done_i && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        conv_start_o = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_next = ST_START;
            ST_START: begin
                conv_start_o = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_done_i)        w_state_next = ST_STORE;
                else if (w_timeout_hit) w_state_next = ST_IDLE;
            end
            ST_STORE: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_sel      <= '0;
            r_op       <= '0;
            r_raw      <= '0;
            r_cnt      <= '0;
            r_tens_cap <= '0;
            r_ones_cap <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sel <= w_pick;
                        r_raw <= w_bin[w_pick];
                        r_op  <= w_op_pick;
                    end
                end
                ST_START: r_cnt <= '0;
                ST_WAIT: begin
                    if (conv_done_i) begin
                        r_tens_cap <= conv_tens_i;
                        r_ones_cap <= conv_ones_i;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_sel_inc;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STORE: r_ptr <= w_sel_inc;
                default: ;
            endcase
        end
    end

    assign conv_bin_o = r_op;
    assign busy_o     = (r_state != ST_IDLE);
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler with a 16-cycle converter model (NUM_CH=2).
module tb_score_bcd_scheduler;

    localparam int NUM_CH  = 2;
    localparam int BIN_W   = 7;
    localparam int TIMEOUT = 31;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NUM_CH*BIN_W-1:0] bin_i = '0;
    logic                 conv_start_o;
    logic [BIN_W-1:0]     conv_bin_o;
    logic                 conv_done_i = 1'b0;
    logic [3:0]           conv_tens_i = '0;
    logic [3:0]           conv_ones_i = '0;
    logic [NUM_CH*4-1:0]  tens_o;
    logic [NUM_CH*4-1:0]  ones_o;
    logic [NUM_CH-1:0]    valid_o;
    logic                 busy_o;
    logic                 timeout_o;

    int n_pass  = 0;
    int n_total = 0;

    score_bcd_scheduler #(
        .NUM_CH  (NUM_CH),
        .BIN_W   (BIN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bin_i        (bin_i),
        .conv_start_o (conv_start_o),
        .conv_bin_o   (conv_bin_o),
        .conv_done_i  (conv_done_i),
        .conv_tens_i  (conv_tens_i),
        .conv_ones_i  (conv_ones_i),
        .tens_o       (tens_o),
        .ones_o       (ones_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Converter model: replies 16 cycles after a start unless cm_never is set.
    bit        cm_never = 1'b0;
    bit        cm_busy  = 1'b0;
    int        cm_cnt   = 0;
    int        cm_op    = 0;
    int        start_log[$];
    logic [7:0] hist0[$];
    logic [7:0] last0 = 8'h00;

    always @(negedge clk_i) begin
        conv_done_i = 1'b0;
        if (rst_i) begin
            cm_busy = 1'b0;
        end else if (cm_busy) begin
            cm_cnt++;
            if (cm_cnt == 16) begin
                conv_done_i = 1'b1;
                conv_tens_i = 4'((cm_op / 10) % 10);
                conv_ones_i = 4'(cm_op % 10);
                cm_busy     = 1'b0;
            end
        end else if (conv_start_o && !cm_never) begin
            cm_busy = 1'b1;
            cm_cnt  = 0;
            cm_op   = int'(conv_bin_o);
        end
    end

    always @(negedge clk_i) begin
        if (conv_start_o) begin
            start_log.push_back(int'(conv_bin_o));
            $display("[%0t] start op=%0d", $time, conv_bin_o);
        end
        if ({tens_o[3:0], ones_o[3:0]} != last0) begin
            last0 = {tens_o[3:0], ones_o[3:0]};
            hist0.push_back(last0);
        end
    end

    task automatic set_bin(input int c0, input int c1);
        bin_i = {7'(c1), 7'(c0)};
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        int low = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            low = busy_o ? 0 : low + 1;
            if (low >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (conv_start_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_bin(42, 7);
        repeat (3) @(negedge clk_i);
        n_total++; if ({tens_o, ones_o} !== 16'h0) $display("FAIL reset_digits: got %h want 0", {tens_o, ones_o}); else n_pass++;
        n_total++; if (valid_o !== 2'b00) $display("FAIL reset_valid: got %b want 00", valid_o); else n_pass++;
        n_total++; if ({busy_o, timeout_o, conv_start_o} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy_o, timeout_o, conv_start_o}); else n_pass++;
        n_total++; if (conv_bin_o !== 7'd0) $display("FAIL reset_conv_bin: got %0d want 0", conv_bin_o); else n_pass++;
    endtask

    task automatic test_first_conversion();
        bit ok;
        start_log.delete();
        rst_i = 1'b0;
        wait_quiet(300, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL first_settle: got %b want 1", ok); else n_pass++;
        n_total++; if (start_log.size() !== 2) $display("FAIL first_start_count: got %0d want 2", start_log.size()); else n_pass++;
        if (start_log.size() == 2) begin
            n_total++; if (start_log[0] !== 42 || start_log[1] !== 7) $display("FAIL first_start_ops: got %0d,%0d want 42,7", start_log[0], start_log[1]); else n_pass++;
        end
        n_total++; if (tens_o !== 8'h04 || ones_o !== 8'h72) $display("FAIL first_digits: got t=%h o=%h want t=04 o=72", tens_o, ones_o); else n_pass++;
        n_total++; if (valid_o !== 2'b11 || busy_o !== 1'b0) $display("FAIL first_valid_busy: got %b/%b want 11/0", valid_o, busy_o); else n_pass++;
    endtask

    task automatic test_change();
        bit ok;
        start_log.delete();
        set_bin(42, 85);
        @(negedge clk_i);
        n_total++; if (conv_start_o !== 1'b1 || conv_bin_o !== 7'd85) $display("FAIL change_latency: got start=%b op=%0d want 1/85", conv_start_o, conv_bin_o); else n_pass++;
        wait_quiet(300, ok);
        n_total++; if (ok !== 1'b1 || start_log.size() !== 1) $display("FAIL change_one_start: got ok=%b n=%0d want 1/1", ok, start_log.size()); else n_pass++;
        n_total++; if (tens_o !== 8'h84 || ones_o !== 8'h52) $display("FAIL change_digits: got t=%h o=%h want t=84 o=52", tens_o, ones_o); else n_pass++;
    endtask

    task automatic test_mid_change();
        bit ok;
        set_bin(30, 85);
        wait_quiet(300, ok);
        start_log.delete();
        hist0.delete();
        set_bin(42, 85);
        wait_start(10, ok);
        repeat (3) @(negedge clk_i);
        set_bin(43, 85);
        wait_quiet(300, ok);
        n_total++; if (ok !== 1'b1 || start_log.size() !== 2) $display("FAIL mid_start_count: got ok=%b n=%0d want 1/2", ok, start_log.size()); else n_pass++;
        if (start_log.size() == 2) begin
            n_total++; if (start_log[0] !== 42 || start_log[1] !== 43) $display("FAIL mid_start_ops: got %0d,%0d want 42,43", start_log[0], start_log[1]); else n_pass++;
        end
        n_total++; if (hist0.size() !== 2) $display("FAIL mid_hist_len: got %0d want 2", hist0.size()); else n_pass++;
        if (hist0.size() == 2) begin
            n_total++; if (hist0[0] !== 8'h42 || hist0[1] !== 8'h43) $display("FAIL mid_hist: got %h,%h want 42,43", hist0[0], hist0[1]); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        @(posedge clk_i);
        cm_never = 1'b1;
        @(negedge clk_i);
        set_bin(55, 20);
        wait_start(5, ok);
        n_total++; if (ok !== 1'b1 || conv_bin_o !== 7'd20) $display("FAIL to_first_start: got ok=%b op=%0d want 1/20", ok, conv_bin_o); else n_pass++;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            k++;
            if (k == TIMEOUT) begin
                n_total++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL to_early: got to=%b busy=%b want 0/1", timeout_o, busy_o); else n_pass++;
            end
            if (!busy_o) break;
        end
        n_total++; if (k !== TIMEOUT + 1) $display("FAIL to_cycles: got %0d want %0d", k, TIMEOUT + 1); else n_pass++;
        n_total++; if (timeout_o !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout_o); else n_pass++;
        @(negedge clk_i);
        n_total++; if (conv_start_o !== 1'b1 || conv_bin_o !== 7'd55) $display("FAIL to_next_channel: got start=%b op=%0d want 1/55", conv_start_o, conv_bin_o); else n_pass++;
        @(posedge clk_i);
        cm_never = 1'b0;
        wait_quiet(400, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL to_settle: got %b want 1", ok); else n_pass++;
        n_total++; if (tens_o !== 8'h25 || ones_o !== 8'h05) $display("FAIL to_recovery_digits: got t=%h o=%h want t=25 o=05", tens_o, ones_o); else n_pass++;
        n_total++; if (timeout_o !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit alt;
        start_log.delete();
        for (int i = 0; i < 100; i++) begin
            set_bin(10 + (i % 40), 60 + (i % 40));
            @(negedge clk_i);
        end
        wait_quiet(300, ok);
        n_total++; if (ok !== 1'b1 || start_log.size() < 4) $display("FAIL b2b_count: got ok=%b n=%0d want 1/>=4", ok, start_log.size()); else n_pass++;
        if (start_log.size() >= 4) begin
            n_total++; if (start_log[0] < 60) $display("FAIL b2b_first_ch: got op %0d want ch1 (>=60)", start_log[0]); else n_pass++;
            alt = 1'b1;
            for (int j = 1; j < 4; j++) begin
                if ((start_log[j] >= 60) == (start_log[j-1] >= 60)) alt = 1'b0;
            end
            n_total++; if (alt !== 1'b1) $display("FAIL b2b_alternate: got %0d,%0d,%0d,%0d want alternating channels", start_log[0], start_log[1], start_log[2], start_log[3]); else n_pass++;
        end
        n_total++; if (tens_o !== 8'h72 || ones_o !== 8'h99) $display("FAIL b2b_final_digits: got t=%h o=%h want t=72 o=99", tens_o, ones_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        set_bin(77, 79);
        wait_start(5, ok);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        n_total++; if ({tens_o, ones_o, valid_o} !== 18'h0) $display("FAIL rst_mid_outputs: got %h want 0", {tens_o, ones_o, valid_o}); else n_pass++;
        n_total++; if ({busy_o, timeout_o, conv_start_o} !== 3'b000 || conv_bin_o !== 7'd0) $display("FAIL rst_mid_flags: got %b op=%0d want 000/0", {busy_o, timeout_o, conv_start_o}, conv_bin_o); else n_pass++;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (conv_start_o !== 1'b0) quiet = 1'b0;
        end
        n_total++; if (quiet !== 1'b1) $display("FAIL rst_mid_no_start: got %b want 1", quiet); else n_pass++;
        start_log.delete();
        rst_i = 1'b0;
        wait_quiet(300, ok);
        n_total++; if (ok !== 1'b1 || start_log.size() !== 2) $display("FAIL rst_mid_reconvert: got ok=%b n=%0d want 1/2", ok, start_log.size()); else n_pass++;
        if (start_log.size() == 2) begin
            n_total++; if (start_log[0] !== 77 || start_log[1] !== 79) $display("FAIL rst_mid_ops: got %0d,%0d want 77,79", start_log[0], start_log[1]); else n_pass++;
        end
        n_total++; if (tens_o !== 8'h77 || ones_o !== 8'h97 || valid_o !== 2'b11) $display("FAIL rst_mid_digits: got t=%h o=%h v=%b want 77/97/11", tens_o, ones_o, valid_o); else n_pass++;
    endtask

    task automatic test_large_value();
        bit ok;
        start_log.delete();
        set_bin(120, 79);
        wait_start(5, ok);
`ifdef SCORE_BCD_CLAMP_EN
        n_total++; if (ok !== 1'b1 || conv_bin_o !== 7'd99) $display("FAIL large_op: got ok=%b op=%0d want 1/99", ok, conv_bin_o); else n_pass++;
`else
        n_total++; if (ok !== 1'b1 || conv_bin_o !== 7'd120) $display("FAIL large_op: got ok=%b op=%0d want 1/120", ok, conv_bin_o); else n_pass++;
`endif
        wait_quiet(300, ok);
        repeat (40) @(negedge clk_i);
        n_total++; if (start_log.size() !== 1) $display("FAIL large_no_repeat: got %0d starts want 1", start_log.size()); else n_pass++;
`ifdef SCORE_BCD_CLAMP_EN
        n_total++; if (tens_o[3:0] !== 4'd9 || ones_o[3:0] !== 4'd9) $display("FAIL large_digits: got %0d/%0d want 9/9", tens_o[3:0], ones_o[3:0]); else n_pass++;
`else
        n_total++; if (tens_o[3:0] !== 4'd2 || ones_o[3:0] !== 4'd0) $display("FAIL large_digits: got %0d/%0d want 2/0", tens_o[3:0], ones_o[3:0]); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_first_conversion();
        test_change();
        test_mid_change();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_large_value();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/score_bcd_scheduler.md
Name: score_bcd_scheduler

Overview:
- Round-robin scheduler that shares one serial binary-to-BCD converter among NUM_CH score channels of the scoreboard.
- Tracks which channels changed since their last conversion and issues one start/done conversion transaction at a time.
- Holds the latest tens/ones digits per channel for the 7-segment display mux.

Parameters:
- NUM_CH, 2, number of score channels sharing the converter (2..8)
- BIN_W, 7, width of each binary score value
- TIMEOUT, 31, maximum cycles in WAIT before the transaction is aborted

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- bin_i  input  NUM_CH*BIN_W  packed score values; channel k occupies bits [k*BIN_W +: BIN_W]
- conv_start_o  output  1  one-cycle start pulse to the converter
- conv_bin_o  output  BIN_W  operand to the converter; stable from start until done
- conv_done_i  input  1  converter result valid, one-cycle pulse
- conv_tens_i  input  4  converter tens digit
- conv_ones_i  input  4  converter ones digit
- tens_o  output  NUM_CH*4  per-channel tens digit, packed like bin_i
- ones_o  output  NUM_CH*4  per-channel ones digit
- valid_o  output  NUM_CH  channel holds at least one completed conversion
- busy_o  output  1  high in every state except IDLE
- timeout_o  output  1  sticky flag, set on an aborted transaction; cleared only by reset

Behaviour:
- Reset values: all outputs 0; shadow registers 0; round-robin pointer 0; state IDLE.
- Per channel, shadow[k] holds the value last converted. Dirty is combinational: dirty[k] = !valid_o[k] || bin_i[k] != shadow[k].
- FSM states: IDLE, START, WAIT, STORE.
- IDLE: if any dirty bit is set, pick the first dirty channel at or after ptr (wrapping), then:
  - latch the channel index into sel and bin_i[sel] into op;
  - go to START.
- IDLE with no dirty channel: stay in IDLE.
- START: conv_start_o=1 for exactly this cycle; conv_bin_o=op; clear the timeout counter; go to WAIT.
- WAIT: conv_bin_o keeps op.
  - conv_done_i=1: capture the digits and go to STORE.
  - Counter reaches TIMEOUT: set timeout_o, ptr<=sel+1 (mod NUM_CH), go to IDLE. The channel stays dirty.
- STORE:
  - tens_o[sel], ones_o[sel] <= captured digits;
  - shadow[sel] <= op; valid_o[sel] <= 1;
  - ptr <= sel+1 (mod NUM_CH); go to IDLE.
- Latency: a change visible in IDLE at cycle t gives conv_start_o at t+1. Outputs update one cycle after conv_done_i is sampled high.
- Input changes during a transaction: the old op completes and is stored. shadow then differs from bin_i, so the channel is re-dirtied and converted again on a later pass.
- Several channels dirty at once: strict round-robin from ptr, so no channel starves.
- conv_done_i outside WAIT: ignored. conv_done_i in the same cycle as the timeout: done wins, no abort.
- Reset mid-transaction: immediate return to reset values. conv_start_o is low and no partial digits are written.
- Width rule: digits are stored verbatim. No arithmetic is done on them here.

Optional Feature:
- Macro: SCORE_BCD_CLAMP_EN.
- Defined: in IDLE the latched op is min(bin_i[sel], 99), so conv_bin_o never exceeds 99. shadow still stores the unclamped value, so a channel held at or above 99 is not re-converted forever.
- Undefined: op = bin_i[sel] unmodified. Values 100..127 yield whatever the converter returns; the hundreds digit is discarded.

Decomposition:
- Shared package score_pkg:
  - FSM state encoding (2 bits);
  - BCD_DIGIT_W=4;
  - MAX_SCORE=99;
  - default TIMEOUT.
- One sub-module, rr_pick:
  - combinational;
  - inputs: NUM_CH dirty vector and ptr;
  - outputs: found flag and selected index.
- All sequencing stays in score_bcd_scheduler.

Test Plan:
- Out of reset, bin_i ch0=42, ch1=7; converter model replies after 16 cycles.
  - Start pulses go to ch0 (op 42), then ch1 (op 7).
  - Final state: tens/ones ch0=4/2, ch1=0/7; valid_o=2'b11; busy_o returns to 0.
- Steady state, ch1 changes 7->85.
  - Exactly one start, with conv_bin_o=85, one cycle after the change.
  - ch1 becomes 8/5; ch0 is untouched.
- During WAIT for ch0=42, change ch0 to 43.
  - 4/2 is stored first.
  - A second transaction then converts 43 to 4/3.
- Converter model never asserts done.
  - After TIMEOUT cycles in WAIT, timeout_o=1 and the FSM returns to IDLE.
  - The next start goes to the following channel.
- Both channels change every cycle continuously.
  - Start pulses alternate ch0, ch1, ch0, ...
- Assert rst_i during WAIT.
  - All outputs return to 0 asynchronously and conv_start_o stays low.
  - After release, both channels are reconverted.
- With SCORE_BCD_CLAMP_EN defined, ch0=120: conv_bin_o=99, digits 9/9, and no repeated conversion.
